// File: rtl/seven_seg_scanner_if.sv
// Purpose : value/load/busy plus digit/position bundle between the datapath,
//           the scanner and the downstream segment/anode decoder.
// Latency : none (wires only).
// Backpressure: busy tells the master that load is ignored until it drops.
// Ports   : value[13:0], load  (master -> slave)
//           busy, digit[3:0], position[1:0]  (slave -> master)
interface seven_seg_scanner_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  digit;
  logic [1:0]  position;

  // Source side of value/load; observes busy and the scanned digit stream.
  modport master (
    output value, load,
    input  busy, digit, position
  );

  // The scanner itself.
  modport slave (
    input  value, load,
    output busy, digit, position
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Purpose : binary (0-9999) to 4-digit BCD via sequential double-dabble,
//           then time-multiplexed onto digit/position.
// Latency : load at edge N -> busy after edges N+1..N+15, new digits from edge N+16.
// Backpressure: load is dropped (not queued) while busy=1; scanning never stalls.
// Ports   : clk, rst_n (async, active-low); io.slave = value, load, busy,
//           digit (0-9, 11 = 'E'), position (0 = ones .. 3 = thousands).
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_seg_scanner_if.slave  io
);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       DIG_E    = 4'd11;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bcd_adj;
  logic [3:0]  step_q, step_d;
  logic        ovf_q, ovf_d;
  logic        commit;
  logic        busy_q;

  logic [15:0]      disp_q;   // nibble i is shown at position i
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       pos_q, pos_next;
  logic [3:0]       digit_q;
  logic             tc;

  // Double-dabble correction: any nibble >= 5 would exceed 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    ovf_d   = ovf_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // busy lags the state by one edge, so both must be clear to accept.
        if (io.load && !busy_q) begin
          state_d = CONVERT;
          bin_d   = io.value;
          bcd_d   = '0;
          step_d  = '0;
          ovf_d   = (io.value > 14'd9999);
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        step_d         = step_q + 4'd1;
        if (step_q == 4'd13)
          state_d = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_q != IDLE);
      if (commit)
        disp_q <= ovf_q ? {4{DIG_E}} : bcd_q;
    end
  end

  // Scanner runs free of the FSM; digit is looked up with the position it
  // will be paired with so the two always change together.
  assign tc       = (cnt_q == CNT_LAST);
  assign pos_next = tc ? pos_q + 2'd1 : pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= tc ? '0 : cnt_q + 1'b1;
      pos_q   <= pos_next;
      digit_q <= disp_q[{pos_next, 2'b00} +: 4];
    end
  end

  assign io.busy     = busy_q;
  assign io.digit    = digit_q;
  assign io.position = pos_q;

endmodule
